seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier, the sequential successor to the single-cycle combinational `multiplier`. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands in signed or unsigned mode, selected per operation by `symbol`. A start/ready/done handshake lets the CPU execute stage stall on it, and a flush input lets the pipeline kill an in-flight operation.

---
 rtl/seq_mul_pkg.sv | 18 +
 rtl/seq_multiplier_if.sv | 30 +++
 rtl/seq_mul_abs.sv | 24 ++
 rtl/seq_multiplier.sv | 143 ++++++++++++++
 tb/tb_seq_multiplier.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding and the encoding of the per-operation
// `symbol` input (signed vs unsigned interpretation of the operands).
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic SYM_SIGNED   = 1'b1;
  localparam logic SYM_UNSIGNED = 1'b0;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the execute stage and seq_multiplier.
// Latency: n/a (wiring only).
// Backpressure: requester holds off `start` while `ready` is low.
//
// master: start, a, b, symbol, flush out; ready, done, o in.
// slave : the reverse (the multiplier side).
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               symbol;
  logic               flush;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] o;

  modport master (
    output start, a, b, symbol, flush,
    input  ready, done, o
  );

  modport slave (
    input  start, a, b, symbol, flush,
    output ready, done, o
  );

endinterface

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement negate: y = neg_en ? -x : x.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x (W bits) in, neg_en in, y (W bits) out.
// Used both to take operand magnitudes and to re-apply the product sign.
// The magnitude of the most negative value wraps to itself, which read as
// unsigned is exactly the required magnitude.
module seq_mul_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg_en,
  output logic [W-1:0] y
);

  always_comb begin
    y = x;
    if (neg_en) begin
      y = ~x + W'(1);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, signed or unsigned per op, 2*WIDTH product.
// Latency: WIDTH+1 edges from accept to `done` (fewer with SEQ_MUL_EARLY_OUT_EN).
// Backpressure: `ready` low while busy; `start` is ignored until IDLE.
//
// Ports: clk, rst_n (async active-low); bus (seq_multiplier_if.slave) carries
// start/a/b/symbol/flush in and ready/done/o out.
// Optional macro SEQ_MUL_EARLY_OUT_EN: stop stepping once the remaining
// multiplier bits are all zero.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_q,  state_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic               neg_q,    neg_d;
  logic [2*WIDTH-1:0] o_q,      o_d;
  logic               done_q,   done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic               last_step;

  assign is_signed = (bus.symbol == SYM_SIGNED);

  seq_mul_abs #(.W(WIDTH)) u_abs_a (
    .x      (bus.a),
    .neg_en (is_signed & bus.a[WIDTH-1]),
    .y      (a_mag)
  );

  seq_mul_abs #(.W(WIDTH)) u_abs_b (
    .x      (bus.b),
    .neg_en (is_signed & bus.b[WIDTH-1]),
    .y      (b_mag)
  );

  seq_mul_abs #(.W(2*WIDTH)) u_sign_fix (
    .x      (acc_q),
    .neg_en (neg_q),
    .y      (prod_signed)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    o_d       = o_q;
    done_d    = 1'b0;
    last_step = 1'b0;

    case (state_q)
      IDLE: begin
        // flush has no meaning here, so a simultaneous start still wins.
        if (bus.start) begin
          state_d  = CALC;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end
      end

      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          // Magnitudes are at most 2^(WIDTH-1)... 2^WIDTH-1, so the
          // accumulator cannot carry out of 2*WIDTH bits.
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef SEQ_MUL_EARLY_OUT_EN
          // No set bits left to add: remaining steps would only shift.
          last_step = last_step | (mplier_d == '0);
`endif
          if (last_step) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!bus.flush) begin
          o_d    = prod_signed;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      o_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      o_q      <= o_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.o     = o_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=32.
// Latency: checks done arrival edge count against hand-computed values.
// Backpressure: checks start is ignored while ready is low.
module tb_seq_multiplier;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected done latency: early-out value when the macro is on, else 33.
  function automatic int lat(input int early);
`ifdef SEQ_MUL_EARLY_OUT_EN
    return early;
`else
    return 33 + (early * 0);
`endif
  endfunction

  // Present a request; returns #1 after the accept edge with start low.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic ts);
    bus.start  = 1'b1;
    bus.a      = ta;
    bus.b      = tb_v;
    bus.symbol = ts;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count edges until done; returns #1 after the edge that raised done.
  task automatic wait_done(input string tag, input int elat,
                           input logic [63:0] eo);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      n++;
      #1 if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_o"}, bus.o, eo);
  endtask

  task automatic no_done(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (bus.done !== 1'b0) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic op(input string tag, input logic [31:0] ta,
                    input logic [31:0] tb_v, input logic ts,
                    input logic [63:0] eo, input int elat);
    @(negedge clk);
    issue(ta, tb_v, ts);
    wait_done(tag, elat, eo);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.symbol = 1'b0;
    bus.flush  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_o", bus.o, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned all-ones, plus busy/pulse-width checks.
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("busy_ready", 64'(bus.ready), 64'd0);
    wait_done("u_ones", 33, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);
    #1 chk("done_pulse", 64'(bus.done), 64'd0);

    op("s_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
       64'h0000_0000_0000_0001, lat(2));
    op("s_7xm3",   32'h0000_0007, 32'hFFFF_FFFD, 1'b1,
       64'hFFFF_FFFF_FFFF_FFEB, lat(3));
    op("s_min2",   32'h8000_0000, 32'h8000_0000, 1'b1,
       64'h4000_0000_0000_0000, lat(33));
    op("u_min2",   32'h8000_0000, 32'h8000_0000, 1'b0,
       64'h4000_0000_0000_0000, 33);
    op("u_minx2",  32'h8000_0000, 32'h0000_0002, 1'b0,
       64'h0000_0001_0000_0000, lat(3));
    op("s_m5x4",   32'hFFFF_FFFB, 32'h0000_0004, 1'b1,
       64'hFFFF_FFFF_FFFF_FFEC, lat(4));
    op("u_bzero",  32'h0000_1234, 32'h0000_0000, 1'b0,
       64'h0, lat(2));
    op("u_b1",     32'hDEAD_BEEF, 32'h0000_0001, 1'b0,
       64'h0000_0000_DEAD_BEEF, lat(2));

    // start while busy is ignored: only one result, original operands.
    @(negedge clk);
    issue(32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'h0000_0011;
    bus.b     = 32'h0000_0022;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("ign_start", 28, 64'h0000_0002_FFFF_FFFD);
    no_done("ign_extra", 40);

    // Flush at CALC cycle 10: no done, o held, ready next cycle.
    @(negedge clk);
    issue(32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.ready), 64'd1);
    chk("flush_o", bus.o, 64'h0000_0002_FFFF_FFFD);
    no_done("flush_nodone", 40);
    chk("flush_o_hold", bus.o, 64'h0000_0002_FFFF_FFFD);

    // Back-to-back: second start issued in the done cycle.
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("b2b_1", 33, 64'hFFFF_FFFE_0000_0001);
    chk("b2b_ready", 64'(bus.ready), 64'd1);
    issue(32'h1234_5678, 32'h0000_0009, 1'b0);
    wait_done("b2b_2", lat(5), 64'h0000_0000_A3D7_0A38);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    issue(32'h0000_0009, 32'hFFFF_FFFF, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_o", bus.o, 64'h0);
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("arst_nodone", 40);

    op("post_rst", 32'h0000_0006, 32'h0000_0007, 1'b0,
       64'h0000_0000_0000_002A, lat(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
